// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

  localparam int unsigned InstW = 32;
  localparam int unsigned LatW  = 3;

  localparam logic [InstW-1:0] ZeroWord = '0;

  // Fetch sequencer states; encodings are fixed so waveforms stay readable.
  typedef enum logic [2:0] {
    FetchIdle      = 3'd0,
    FetchWaitGrant = 3'd1,
    FetchIssue     = 3'd2,
    FetchWait      = 3'd3,
    FetchFill      = 3'd4,
    FetchDone      = 3'd5
  } fetch_state_e;

  // Replace one little-endian byte lane of a word.
  function automatic logic [InstW-1:0] set_byte_lane(input logic [InstW-1:0] word,
                                                     input logic [1:0]       lane,
                                                     input logic [7:0]       data);
    logic [InstW-1:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      default: res[31:24] = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: cache lookup on each fetch, byte-serial refill
// over the shared memory bus on a miss, and flush (redirect) at any point.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,  // 1..4 cycles from mem_rd to valid mem_din
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  // IF stage
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic              if_ready,
  output logic [InstW-1:0]  if_inst,
  // inst_cache lookup
  output logic              cache_query,
  output logic [ADDR_W-1:0] query_addr,
  input  logic              cache_hit_i,
  input  logic [InstW-1:0]  cache_inst_i,
  // inst_cache fill
  output logic              cache_enable,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [InstW-1:0]  cache_data,
  // memory arbiter / byte bus
  output logic              mem_req,
  input  logic              mem_grant,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_din
);

  localparam logic [LatW-1:0] LatInit = LatW'(MEM_LATENCY);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;   // miss address, base of the byte reads
  logic [1:0]        k_q, k_d;         // byte lane being fetched
  logic [LatW-1:0]   lat_q, lat_d;     // cycles left until mem_din is valid
  logic [InstW-1:0]  word_q, word_d;   // hit word or byte-assembly register

  // Next-state, datapath updates and all outputs; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    k_d          = k_q;
    lat_d        = lat_q;
    word_d       = word_q;
    if_ready     = 1'b0;
    if_inst      = ZeroWord;
    cache_query  = 1'b0;
    query_addr   = '0;
    cache_enable = 1'b0;
    cache_addr   = '0;
    cache_data   = ZeroWord;
    mem_req      = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = '0;

    if (flush) begin
      // Partial word is simply abandoned; the next miss overwrites every lane.
      state_d = FetchIdle;
    end else begin
      case (state_q)
        FetchIdle: begin
          if (if_req) begin
            cache_query = 1'b1;
            query_addr  = if_addr;
            if (cache_hit_i) begin
              word_d  = cache_inst_i;
              state_d = FetchDone;
            end else begin
              addr_d  = if_addr;
              state_d = FetchWaitGrant;
            end
          end
        end
        FetchWaitGrant: begin
          mem_req = 1'b1;
          if (mem_grant) begin
            k_d     = 2'd0;
            state_d = FetchIssue;
          end
        end
        FetchIssue: begin
          mem_req  = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = addr_q + ADDR_W'(k_q);
          lat_d    = LatInit;
          state_d  = FetchWait;
        end
        FetchWait: begin
          mem_req = 1'b1;
          lat_d   = lat_q - LatW'(1);
          if (lat_q == LatW'(1)) begin
            word_d = set_byte_lane(word_q, k_q, mem_din);
            if (k_q == 2'd3) begin
              state_d = FetchFill;
            end else begin
              k_d     = k_q + 2'd1;
              state_d = FetchIssue;
            end
          end
        end
        FetchFill: begin
          cache_enable = 1'b1;
          cache_addr   = addr_q;
          cache_data   = word_q;
          if_ready     = 1'b1;
          if_inst      = word_q;
          state_d      = FetchIdle;
        end
        FetchDone: begin
          if_ready = 1'b1;
          if_inst  = word_q;
          state_d  = FetchIdle;
        end
        default: state_d = FetchIdle;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FetchIdle;
      addr_q  <= '0;
      k_q     <= 2'd0;
      lat_q   <= '0;
      word_q  <= ZeroWord;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      lat_q   <= lat_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl with a cache model, byte memory model
// and arbiter model; expected instructions go through a scoreboard queue.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_inst;
  logic        cache_query;
  logic [31:0] query_addr;
  logic        cache_hit_i;
  logic [31:0] cache_inst_i;
  logic        cache_enable;
  logic [31:0] cache_addr, cache_data;
  logic        mem_req, mem_grant, mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];   // scoreboard of expected instructions
  logic [31:0] rd_q[$];    // every mem_addr seen on a mem_rd cycle

  always #5 clk = ~clk;

  inst_fetch_ctrl #(
    .MEM_LATENCY(1),
    .ADDR_W     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .flush       (flush),
    .if_ready    (if_ready),
    .if_inst     (if_inst),
    .cache_query (cache_query),
    .query_addr  (query_addr),
    .cache_hit_i (cache_hit_i),
    .cache_inst_i(cache_inst_i),
    .cache_enable(cache_enable),
    .cache_addr  (cache_addr),
    .cache_data  (cache_data),
    .mem_req     (mem_req),
    .mem_grant   (mem_grant),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din)
  );

  // Byte memory contents: fixed bytes at 0x80..0x83, address hash elsewhere.
  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'h80:  return 8'h13;
      32'h81:  return 8'h05;
      32'h82:  return 8'hA0;
      32'h83:  return 8'h00;
      default: return a[7:0] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  // Direct-mapped cache model, 256 lines, full-address tag.
  logic        c_vld [256];
  logic [31:0] c_tag [256];
  logic [31:0] c_dat [256];
  logic        pre_we, cache_clr;
  logic [31:0] pre_addr, pre_data;

  always @(posedge clk) begin
    if (cache_clr) begin
      for (int i = 0; i < 256; i++) c_vld[i] <= 1'b0;
    end else if (pre_we) begin
      c_vld[pre_addr[9:2]] <= 1'b1;
      c_tag[pre_addr[9:2]] <= pre_addr;
      c_dat[pre_addr[9:2]] <= pre_data;
    end else if (cache_enable) begin
      c_vld[cache_addr[9:2]] <= 1'b1;
      c_tag[cache_addr[9:2]] <= cache_addr;
      c_dat[cache_addr[9:2]] <= cache_data;
    end
  end

  always_comb begin
    cache_hit_i  = 1'b0;
    cache_inst_i = 32'h0;
    if (c_vld[query_addr[9:2]] === 1'b1 && c_tag[query_addr[9:2]] == query_addr) begin
      cache_hit_i  = 1'b1;
      cache_inst_i = c_dat[query_addr[9:2]];
    end
  end

  // Memory returns the byte one cycle after mem_rd; junk otherwise.
  always @(posedge clk) begin
    mem_din <= mem_rd ? mb(mem_addr) : 8'hEE;
    if (mem_rd) rd_q.push_back(mem_addr);
  end

  // Arbiter: grant after grant_delay cycles of continuous mem_req.
  int grant_delay = 0;
  int gcnt = 0;
  always @(posedge clk) gcnt <= mem_req ? gcnt + 1 : 0;
  assign mem_grant = mem_req && (gcnt >= grant_delay);

  // Drive one fetch and observe until if_ready or budget; no checking here.
  task automatic fetch(input logic [31:0] a, output int lat, output logic got,
                       output logic [31:0] inst, output logic saw_req,
                       output logic fill_seen, output logic [31:0] fill_addr,
                       output logic [31:0] fill_data, output int first_rd);
    lat = 0; got = 1'b0; inst = '0; saw_req = 1'b0; fill_seen = 1'b0;
    fill_addr = '0; fill_data = '0; first_rd = -1;
    @(negedge clk);
    if_addr = a;
    if_req  = 1'b1;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (mem_req) saw_req = 1'b1;
      if (mem_rd && first_rd < 0) first_rd = lat;
      if (if_ready) begin
        got = 1'b1; inst = if_inst; fill_seen = cache_enable;
        fill_addr = cache_addr; fill_data = cache_data;
      end
    end
    if_req = 1'b0;
  endtask

  int          lat, first_rd, base;
  logic        got, saw_req, fill_seen;
  logic [31:0] inst, fill_addr, fill_data, exp;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({if_ready, cache_query, mem_req, mem_rd, cache_enable} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {if_ready, cache_query, mem_req, mem_rd, cache_enable});
    end
    n_vec++;
    if ({if_inst, mem_addr, cache_addr, cache_data, query_addr} !== 160'b0) begin
      n_err++;
      $display("FAIL reset_data: got if_inst=%h mem_addr=%h cache_addr=%h want all 0",
               if_inst, mem_addr, cache_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_hit();
    exp_q.push_back(32'h0010_0093);
    fetch(32'h40, lat, got, inst, saw_req, fill_seen, fill_addr, fill_data, first_rd);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== 1'b1 || lat != 1) begin
      n_err++; $display("FAIL hit_latency: got %0d (ready=%b) want 1", lat, got);
    end
    n_vec++;
    if (inst !== exp) begin n_err++; $display("FAIL hit_inst: got %h want %h", inst, exp); end
    n_vec++;
    if (saw_req !== 1'b0 || fill_seen !== 1'b0) begin
      n_err++; $display("FAIL hit_no_mem: got req=%b fill=%b want 0 0", saw_req, fill_seen);
    end
  endtask

  task automatic test_miss();
    logic [31:0] want_rd [4];
    want_rd[0] = 32'h80; want_rd[1] = 32'h81; want_rd[2] = 32'h82; want_rd[3] = 32'h83;
    base = rd_q.size();
    exp_q.push_back(32'h00A0_0513);
    fetch(32'h80, lat, got, inst, saw_req, fill_seen, fill_addr, fill_data, first_rd);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== 1'b1 || lat != 10) begin
      n_err++; $display("FAIL miss_latency: got %0d (ready=%b) want 10", lat, got);
    end
    n_vec++;
    if (inst !== exp) begin n_err++; $display("FAIL miss_inst: got %h want %h", inst, exp); end
    n_vec++;
    if (fill_seen !== 1'b1 || fill_addr !== 32'h80 || fill_data !== exp) begin
      n_err++;
      $display("FAIL miss_fill: got en=%b addr=%h data=%h want 1 00000080 %h",
               fill_seen, fill_addr, fill_data, exp);
    end
    n_vec++;
    if (first_rd != 2) begin n_err++; $display("FAIL miss_first_rd: got %0d want 2", first_rd); end
    n_vec++;
    if (rd_q.size() != base + 4) begin
      n_err++; $display("FAIL miss_rd_count: got %0d want 4", rd_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (rd_q[base + i] !== want_rd[i]) begin
          n_err++;
          $display("FAIL miss_rd_addr%0d: got %h want %h", i, rd_q[base + i], want_rd[i]);
        end
      end
    end
    // Same address again must now hit.
    exp_q.push_back(32'h00A0_0513);
    fetch(32'h80, lat, got, inst, saw_req, fill_seen, fill_addr, fill_data, first_rd);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat != 1 || inst !== exp || saw_req !== 1'b0) begin
      n_err++;
      $display("FAIL refetch_hit: got lat=%0d inst=%h req=%b want 1 %h 0", lat, inst, saw_req, exp);
    end
  endtask

  task automatic test_grant_delay();
    grant_delay = 5;
    exp_q.push_back(mem_word(32'h100));
    fetch(32'h100, lat, got, inst, saw_req, fill_seen, fill_addr, fill_data, first_rd);
    exp = exp_q.pop_front();
    grant_delay = 0;
    n_vec++;
    if (lat != 15) begin n_err++; $display("FAIL grant_latency: got %0d want 15", lat); end
    n_vec++;
    if (first_rd != 7) begin n_err++; $display("FAIL grant_first_rd: got %0d want 7", first_rd); end
    n_vec++;
    if (inst !== exp) begin n_err++; $display("FAIL grant_inst: got %h want %h", inst, exp); end
  endtask

  task automatic test_flush_mid_miss();
    logic seen, bad;
    seen = 1'b0; bad = 1'b0;
    @(negedge clk);
    if_addr = 32'h200;
    if_req  = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 32'h202) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b1) begin n_err++; $display("FAIL flush_byte2_seen: got 0 want 1"); end
    @(negedge clk);  // WAIT of byte 2
    flush  = 1'b1;
    if_req = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, mem_rd, cache_enable, if_ready} !== 4'b0) begin
      n_err++;
      $display("FAIL flush_cycle_outputs: got %b want 0000",
               {mem_req, mem_rd, cache_enable, if_ready});
    end
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_req || mem_rd || cache_enable || if_ready) bad = 1'b1;
    end
    n_vec++;
    if (bad !== 1'b0) begin n_err++; $display("FAIL flush_idle_after: got active want quiet"); end
    exp_q.push_back(mem_word(32'h200));
    fetch(32'h200, lat, got, inst, saw_req, fill_seen, fill_addr, fill_data, first_rd);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat != 10 || inst !== exp) begin
      n_err++; $display("FAIL flush_refetch: got lat=%0d inst=%h want 10 %h", lat, inst, exp);
    end
  endtask

  task automatic test_flush_with_req();
    @(negedge clk);
    if_addr = 32'h40;
    if_req  = 1'b1;
    flush   = 1'b1;
    #1;
    n_vec++;
    if (cache_query !== 1'b0) begin
      n_err++; $display("FAIL flush_req_query: got %b want 0", cache_query);
    end
    @(negedge clk);
    n_vec++;
    if ({if_ready, mem_req, cache_query} !== 3'b0) begin
      n_err++;
      $display("FAIL flush_req_state: got %b want 000", {if_ready, mem_req, cache_query});
    end
    if_req = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] want_rd [4];
    @(negedge clk);
    if_addr = 32'h400;
    if_req  = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    if_req = 1'b0;
    rst    = 1'b1;
    #1;
    n_vec++;
    if ({if_ready, cache_query, mem_req, mem_rd, cache_enable} !== 5'b0 ||
        mem_addr !== 32'h0 || if_inst !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset_outputs: got ctrl=%b mem_addr=%h want 0",
               {if_ready, cache_query, mem_req, mem_rd, cache_enable}, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    want_rd[0] = 32'hFFFF_FFFE; want_rd[1] = 32'hFFFF_FFFF;
    want_rd[2] = 32'h0;         want_rd[3] = 32'h1;
    base = rd_q.size();
    exp_q.push_back(mem_word(32'hFFFF_FFFE));
    fetch(32'hFFFF_FFFE, lat, got, inst, saw_req, fill_seen, fill_addr, fill_data, first_rd);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat != 10 || inst !== exp) begin
      n_err++; $display("FAIL wrap_fetch: got lat=%0d inst=%h want 10 %h", lat, inst, exp);
    end
    n_vec++;
    if (rd_q.size() != base + 4) begin
      n_err++; $display("FAIL wrap_rd_count: got %0d want 4", rd_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (rd_q[base + i] !== want_rd[i]) begin
          n_err++;
          $display("FAIL wrap_rd_addr%0d: got %h want %h", i, rd_q[base + i], want_rd[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; flush = 1'b0; if_addr = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; cache_clr = 1'b1;
    @(negedge clk);
    cache_clr = 1'b0;
    pre_we = 1'b1; pre_addr = 32'h40; pre_data = 32'h0010_0093;
    @(negedge clk);
    pre_we = 1'b0;
    test_reset();
    test_hit();
    test_miss();
    test_grant_delay();
    test_flush_mid_miss();
    test_flush_with_req();
    test_reset_mid_miss();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences the direct-mapped instruction cache for the IF stage.
- Queries the cache for each fetch. On a miss it requests the byte-wide memory bus from the memory arbiter, reads four bytes little-endian, assembles the word, fills the cache and returns the instruction to IF.
- Sits between the IF stage, inst_cache and the memory arbiter.
- Handles pipeline flush (branch redirect) at any point in a fetch.

Parameters:
- MEM_LATENCY, 1: cycles from mem_rd issue to valid mem_din (1..4).
- ADDR_W, 32: instruction address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF requests instruction at if_addr
- if_addr  in  ADDR_W  fetch address (byte address)
- flush  in  1  abort current fetch (redirect)
- if_ready  out  1  one-cycle pulse: if_inst valid
- if_inst  out  32  fetched instruction
- cache_query  out  1  cache lookup strobe
- query_addr  out  ADDR_W  lookup address
- cache_hit_i  in  1  cache hit (combinational from cache)
- cache_inst_i  in  32  cache data on hit
- cache_enable  out  1  one-cycle cache write strobe
- cache_addr  out  ADDR_W  fill address
- cache_data  out  32  fill word
- mem_req  out  1  bus request to arbiter
- mem_grant  in  1  bus granted; arbiter holds it while mem_req stays high
- mem_rd  out  1  byte read strobe
- mem_addr  out  ADDR_W  byte address
- mem_din  in  8  read byte

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0, latched address 0, byte counter 0, assembly register 0.
- States:
  - IDLE: cache_query = if_req & ~flush; query_addr = if_addr (combinational). If querying:
    - on hit, latch cache_inst_i → DONE;
    - on miss, latch if_addr → WAIT_GRANT.
  - WAIT_GRANT: mem_req = 1. Stays here until mem_grant; then → ISSUE with k = 0.
  - ISSUE: mem_req = 1, mem_rd = 1, mem_addr = addr + k (ADDR_W wrap-around allowed). → WAIT with latency counter = MEM_LATENCY.
  - WAIT: mem_req = 1. Counter decrements each cycle. When the counter reaches 1, capture mem_din into byte lane k (bits 8k+7:8k), then:
    - if k < 3: k + 1 → ISSUE;
    - if k == 3: → FILL.
  - FILL: mem_req = 0, cache_enable = 1, cache_addr = addr, cache_data = assembled word, if_ready = 1, if_inst = assembled word. → IDLE.
  - DONE: if_ready = 1, if_inst = latched hit word. → IDLE.
- Latency:
  - hit: 1 cycle from if_req to if_ready;
  - miss with immediate grant: 2 + 4 × (1 + MEM_LATENCY) cycles (10 for MEM_LATENCY = 1).
- Handshake: if_req is held by IF until if_ready. No new request is accepted in the cycle if_ready pulses; earliest acceptance is the next IDLE cycle.
- Flush:
  - Any state → IDLE next cycle.
  - mem_req, mem_rd, cache_enable and if_ready forced 0 in the flush cycle.
  - No cache fill, partial word discarded.
  - flush with if_req in the same cycle: flush wins and no query is made.
  - Late mem_din after a flush is ignored, because capture happens only in WAIT.
- Grant withdrawn while mem_req is high is an arbiter protocol error. The controller does not check it.
- if_addr[1:0] is passed unmodified; alignment is enforced by IF.
- mem_req drops exactly in the FILL cycle or on flush; it is never asserted in IDLE or DONE.

Decomposition:
- defines.v holds:
  - state encodings: `FetchIdle, `FetchWaitGrant, `FetchIssue, `FetchWait, `FetchFill, `FetchDone (3 bits);
  - existing `InstAddrBus, `InstBus, `ZeroWord.
- No sub-module: the byte assembly is a 32-bit register with lane select inside this block.

Test Plan:
- Hit: cache preloaded at 0x0000_0040 = 0x0010_0093; if_req at 0x40 → if_ready after 1 cycle with 0x0010_0093; mem_req never asserted.
- Miss, MEM_LATENCY = 1, grant immediate, memory bytes 0x13,0x05,0xA0,0x00 at 0x80..0x83 → mem_addr 0x80,0x81,0x82,0x83 on mem_rd cycles; if_ready and cache_enable together at cycle 10 with 0x00A0_0513, cache_addr 0x80; a repeat fetch of 0x80 then hits in 1 cycle.
- Grant delayed 5 cycles → mem_req held high and no mem_rd until grant; completion shifted by exactly 5 cycles.
- Flush raised during WAIT of byte 2 → next cycle IDLE, mem_req 0, no cache_enable, no if_ready; a following fetch of the same address misses again.
- Flush and if_req in the same IDLE cycle → no cache_query, no state change.
- Reset asserted mid-miss (asynchronous, between clock edges) → all outputs 0 immediately, state IDLE; after release, a fetch at 0xFFFF_FFFE wraps mem_addr to 0x0000_0001 for the last byte.
